// File: rtl/nfca_rx_tobits.sv
// NFC-A PICC->PCD Manchester bit decoder (106 kbps, 847.5 kHz subcarrier).
// Each bit is 8 subcarrier periods. Periods 0..3 are the first half and
// periods 4..7 the second half. A half counts as modulated when at least
// THRESHOLD of its 4 periods carry load modulation.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for the first modulated period, which starts S
// START | collecting the S bit; a valid S is (1,0), anything else is noise
// DATA  | decoding data bits; (0,0) is E and (1,1) is a collision
// DONE  | frame ended; ignore the subcarrier until rx_on drops
module nfca_rx_tobits #(
  parameter int THRESHOLD = 3,
  parameter int MAX_BITS  = 2400,
  parameter int CNT_W     = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx_on,
  input  logic rx_ask_en,
  input  logic rx_ask,
  output logic rx_bit_en,
  output logic rx_bit,
  output logic rx_end,
  output logic rx_end_col,
  output logic rx_end_err,
  output logic rx_busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  localparam logic [2:0]       THR  = 3'(THRESHOLD);
  localparam logic [CNT_W-1:0] BMAX = CNT_W'(MAX_BITS);

  state_t           state;
  logic [2:0]       pcnt;
  logic [2:0]       a1;
  logic [2:0]       a2;
  logic [CNT_W-1:0] bcnt;

  logic [2:0] a1_nxt;
  logic [2:0] a2_fin;
  logic       h1;
  logic       h2;
  logic       last_per;

  // Half-bit decisions; the second half includes the period being sampled now.
  always_comb begin
    a1_nxt   = a1 + {2'b00, rx_ask};
    a2_fin   = a2 + {2'b00, rx_ask};
    h1       = (a1 >= THR);
    h2       = (a2_fin >= THR);
    last_per = (pcnt == 3'd7);
  end

  // Decoder FSM with registered single-cycle output pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      pcnt       <= '0;
      a1         <= '0;
      a2         <= '0;
      bcnt       <= '0;
      rx_bit_en  <= 1'b0;
      rx_bit     <= 1'b0;
      rx_end     <= 1'b0;
      rx_end_col <= 1'b0;
      rx_end_err <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_bit_en  <= 1'b0;
      rx_end     <= 1'b0;
      rx_end_col <= 1'b0;
      rx_end_err <= 1'b0;
      if (!rx_on) begin
        // Abort wins over any simultaneous subcarrier sample; no rx_end here,
        // the byte assembler handles the abort on its own.
        state   <= IDLE;
        pcnt    <= '0;
        a1      <= '0;
        a2      <= '0;
        bcnt    <= '0;
        rx_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_ask_en && rx_ask) begin
              a1    <= 3'd1;
              a2    <= '0;
              pcnt  <= 3'd1;
              bcnt  <= '0;
              state <= START;
            end
          end
          START, DATA: begin
            if (rx_ask_en) begin
              if (!last_per) begin
                pcnt <= pcnt + 3'd1;
                if (pcnt[2]) a2 <= a2_fin;
                else         a1 <= a1_nxt;
              end else begin
                pcnt <= '0;
                a1   <= '0;
                a2   <= '0;
                if (state == START) begin
                  if (h1 && !h2) begin
                    state   <= DATA;
                    rx_busy <= 1'b1;
                  end else begin
                    state <= IDLE;
                  end
                end else begin
                  case ({h1, h2})
                    2'b10, 2'b01: begin
                      if (bcnt == BMAX) begin
                        rx_end     <= 1'b1;
                        rx_end_err <= 1'b1;
                        state      <= DONE;
                      end else begin
                        rx_bit_en <= 1'b1;
                        rx_bit    <= h1;
                        bcnt      <= bcnt + CNT_W'(1);
                      end
                    end
                    2'b00: begin
                      rx_end <= 1'b1;
                      state  <= DONE;
                    end
                    default: begin
                      rx_end     <= 1'b1;
                      rx_end_col <= 1'b1;
                      state      <= DONE;
                    end
                  endcase
                end
              end
            end
          end
          DONE: begin
            // rx_busy stays high through the rx_end cycle, then drops here.
            rx_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nfca_rx_tobits.sv
// Directed bench for nfca_rx_tobits; built with MAX_BITS=4 so the
// overlength case stays short.
module tb_nfca_rx_tobits;

  logic clk = 1'b0;
  logic rstn;
  logic rx_on;
  logic rx_ask_en;
  logic rx_ask;
  logic rx_bit_en;
  logic rx_bit;
  logic rx_end;
  logic rx_end_col;
  logic rx_end_err;
  logic rx_busy;

  int checks = 0;
  int errors = 0;

  // Event log filled by the monitor
  int   n_bit_en = 0;
  int   n_end    = 0;
  int   n_excl   = 0;
  int   n_busy   = 0;
  logic last_col = 1'b0;
  logic last_err = 1'b0;
  logic busy_at_end = 1'b0;
  logic bits_log [0:63];

  localparam logic [7:0] B1 = 8'hF0;
  localparam logic [7:0] B0 = 8'h0F;
  localparam logic [7:0] BE = 8'h00;
  localparam logic [7:0] BC = 8'hFF;

  always #5 clk = ~clk;

  nfca_rx_tobits #(.THRESHOLD(3), .MAX_BITS(4), .CNT_W(12)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_on      (rx_on),
    .rx_ask_en  (rx_ask_en),
    .rx_ask     (rx_ask),
    .rx_bit_en  (rx_bit_en),
    .rx_bit     (rx_bit),
    .rx_end     (rx_end),
    .rx_end_col (rx_end_col),
    .rx_end_err (rx_end_err),
    .rx_busy    (rx_busy)
  );

  // Record output events away from the active edge
  always @(negedge clk) begin
    if (rx_bit_en) begin
      bits_log[n_bit_en % 64] = rx_bit;
      n_bit_en = n_bit_en + 1;
    end
    if (rx_end) begin
      n_end       = n_end + 1;
      last_col    = rx_end_col;
      last_err    = rx_end_err;
      busy_at_end = rx_busy;
    end
    if (rx_bit_en && rx_end) n_excl = n_excl + 1;
    if (rx_busy) n_busy = n_busy + 1;
  end

  task automatic send_period(input logic a);
    @(negedge clk); rx_ask_en = 1'b1; rx_ask = a;
    @(negedge clk); rx_ask_en = 1'b0; rx_ask = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bit(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) send_period(p[i]);
  endtask

  task automatic rearm();
    @(negedge clk); rx_on = 1'b0;
    repeat (3) @(negedge clk);
    rx_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err, rx_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err, rx_busy});
    end
  endtask

  task automatic test_data_frame();
    int bb, eb;
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    bb = n_bit_en; eb = n_end;
    rx_on = 1'b1;
    send_bit(B1);
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL data_busy_after_s: got %b expected 1", rx_busy); end
    send_bit(B1); send_bit(B0); send_bit(B1); send_bit(B1);
    send_bit(BE);
    checks++;
    if (n_bit_en - bb !== 4) begin errors++; $display("FAIL data_bit_count: got %0d expected 4", n_bit_en - bb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bits_log[(bb + i) % 64] !== exp_bits[3-i]) begin
        errors++; $display("FAIL data_bit%0d: got %b expected %b", i, bits_log[(bb + i) % 64], exp_bits[3-i]);
      end
    end
    checks++;
    if ({n_end - eb, last_col, last_err, busy_at_end} !== {32'd1, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL data_end: got ends=%0d col=%b err=%b busy=%b expected 1 0 0 1",
                         n_end - eb, last_col, last_err, busy_at_end);
    end
    checks++;
    if ({rx_busy, rx_bit} !== 2'b01) begin
      errors++; $display("FAIL data_after_end: got busy,bit=%b expected 01", {rx_busy, rx_bit});
    end
    rearm();
  endtask

  task automatic test_collision();
    int bb, eb;
    bb = n_bit_en; eb = n_end;
    send_bit(B1);
    send_bit(B0);
    for (int i = 0; i < 7; i++) send_period(1'b1);
    @(negedge clk); rx_ask_en = 1'b1; rx_ask = 1'b1;
    @(negedge clk); rx_ask_en = 1'b0; rx_ask = 1'b0;
    checks++;
    if ({rx_end, rx_end_col, rx_end_err, rx_bit_en} !== 4'b1100) begin
      errors++; $display("FAIL col_pulse: got end,col,err,bit_en=%b expected 1100",
                         {rx_end, rx_end_col, rx_end_err, rx_bit_en});
    end
    repeat (2) @(negedge clk);
    send_bit(B1); send_bit(B0); send_bit(BC);
    checks++;
    if ({n_bit_en - bb, n_end - eb} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL col_counts: got bits=%0d ends=%0d expected 1 1", n_bit_en - bb, n_end - eb);
    end
    checks++;
    if (bits_log[bb % 64] !== 1'b0) begin
      errors++; $display("FAIL col_bit: got %b expected 0", bits_log[bb % 64]);
    end
    rearm();
  endtask

  task automatic test_noise();
    int bb, eb, bu;
    bb = n_bit_en; eb = n_end; bu = n_busy;
    send_bit(8'h80);
    checks++;
    if ({n_bit_en - bb, n_end - eb, n_busy - bu} !== {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL noise_quiet: got bits=%0d ends=%0d busy_cycles=%0d expected 0 0 0",
                         n_bit_en - bb, n_end - eb, n_busy - bu);
    end
    send_bit(B1);
    send_bit(8'hE1);
    send_bit(BE);
    checks++;
    if ({n_bit_en - bb, n_end - eb} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL noise_counts: got bits=%0d ends=%0d expected 1 1", n_bit_en - bb, n_end - eb);
    end
    checks++;
    if ({bits_log[bb % 64], last_col, last_err} !== 3'b100) begin
      errors++; $display("FAIL noise_bit: got bit,col,err=%b expected 100",
                         {bits_log[bb % 64], last_col, last_err});
    end
    rearm();
  endtask

  task automatic test_overlength();
    int bb, eb;
    logic [3:0] exp_bits;
    exp_bits = 4'b1001;
    bb = n_bit_en; eb = n_end;
    send_bit(B1);
    send_bit(B1); send_bit(B0); send_bit(B0); send_bit(B1);
    send_bit(B1);
    checks++;
    if ({n_bit_en - bb, n_end - eb} !== {32'd4, 32'd1}) begin
      errors++; $display("FAIL ovl_counts: got bits=%0d ends=%0d expected 4 1", n_bit_en - bb, n_end - eb);
    end
    checks++;
    if ({last_err, last_col} !== 2'b10) begin
      errors++; $display("FAIL ovl_flags: got err,col=%b expected 10", {last_err, last_col});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bits_log[(bb + i) % 64] !== exp_bits[3-i]) begin
        errors++; $display("FAIL ovl_bit%0d: got %b expected %b", i, bits_log[(bb + i) % 64], exp_bits[3-i]);
      end
    end
    rearm();
  endtask

  task automatic test_abort();
    int bb, eb;
    logic [7:0] p;
    p = B0;
    bb = n_bit_en; eb = n_end;
    send_bit(B1);
    send_bit(B1);
    for (int i = 7; i >= 1; i--) send_period(p[i]);
    @(negedge clk); rx_ask_en = 1'b1; rx_ask = p[0]; rx_on = 1'b0;
    @(negedge clk); rx_ask_en = 1'b0; rx_ask = 1'b0;
    checks++;
    if ({rx_bit_en, rx_end, rx_busy} !== 3'b000) begin
      errors++; $display("FAIL abort_quiet: got bit_en,end,busy=%b expected 000", {rx_bit_en, rx_end, rx_busy});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({n_bit_en - bb, n_end - eb} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL abort_counts: got bits=%0d ends=%0d expected 1 0", n_bit_en - bb, n_end - eb);
    end
    rx_on = 1'b1;
    @(negedge clk);
    bb = n_bit_en; eb = n_end;
    send_bit(B1);
    send_bit(B0); send_bit(B1);
    send_bit(BE);
    checks++;
    if ({n_bit_en - bb, n_end - eb, bits_log[bb % 64], bits_log[(bb + 1) % 64], last_col, last_err}
        !== {32'd2, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL abort_rearm: got bits=%0d ends=%0d b0=%b b1=%b col=%b err=%b expected 2 1 0 1 0 0",
                         n_bit_en - bb, n_end - eb, bits_log[bb % 64], bits_log[(bb + 1) % 64], last_col, last_err);
    end
    rearm();
  endtask

  task automatic test_reset_mid();
    int bb, eb;
    send_bit(B1);
    send_bit(B1);
    for (int i = 0; i < 3; i++) send_period(1'b0);
    checks++;
    if ({rx_busy, rx_bit} !== 2'b11) begin
      errors++; $display("FAIL rst_pre: got busy,bit=%b expected 11", {rx_busy, rx_bit});
    end
    @(negedge clk); rstn = 1'b0;
    #1;
    checks++;
    if ({rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err, rx_busy} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b expected 000000",
                         {rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err, rx_busy});
    end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    bb = n_bit_en; eb = n_end;
    send_bit(B1);
    send_bit(B1); send_bit(B0);
    send_bit(BE);
    checks++;
    if ({n_bit_en - bb, n_end - eb, bits_log[bb % 64], bits_log[(bb + 1) % 64], last_col, last_err}
        !== {32'd2, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_fresh_frame: got bits=%0d ends=%0d b0=%b b1=%b col=%b err=%b expected 2 1 1 0 0 0",
                         n_bit_en - bb, n_end - eb, bits_log[bb % 64], bits_log[(bb + 1) % 64], last_col, last_err);
    end
  endtask

  initial begin
    rstn = 1'b0; rx_on = 1'b0; rx_ask_en = 1'b0; rx_ask = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_data_frame();
    test_collision();
    test_noise();
    test_overlength();
    test_abort();
    test_reset_mid();
    checks++;
    if (n_excl !== 0) begin
      errors++; $display("FAIL exclusivity: got %0d overlapping cycles expected 0", n_excl);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
